// File: rtl/control_decoder_pkg.sv
// Shared encodings for the RV32I main control decoder: ALU ops, immediate
// formats, writeback sources and the packed control word.
package control_decoder_pkg;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0001;
  localparam logic [3:0] ALU_SLL    = 4'b0010;
  localparam logic [3:0] ALU_SLT    = 4'b0011;
  localparam logic [3:0] ALU_SLTU   = 4'b0100;
  localparam logic [3:0] ALU_XOR    = 4'b0101;
  localparam logic [3:0] ALU_SRL    = 4'b0110;
  localparam logic [3:0] ALU_SRA    = 4'b0111;
  localparam logic [3:0] ALU_OR     = 4'b1000;
  localparam logic [3:0] ALU_AND    = 4'b1001;
  localparam logic [3:0] ALU_PASS_B = 4'b1111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef struct packed {
    logic       load;
    logic       store;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       mem_en;
    logic       operand_b;
    logic       operand_a;
    logic [2:0] imm_sel;
    logic       branch;
    logic       next_sel;
    logic [3:0] alu_control;
  } ctrl_t;

  // Register-register ops use funct7[5] for both SUB and SRA; immediate ops
  // only for SRAI, since ADDI has no subtract form.
  function automatic logic [3:0] alu_op(input logic [2:0] fun3, input logic fun7,
                                        input logic is_r);
    logic [3:0] op;
    unique case (fun3)
      3'b000:  op = (is_r && fun7) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = fun7 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/control_decode_comb.sv
// Combinational decode of instruction-class strobes plus funct3/funct7[5]
// into the next datapath control word, with fixed strobe priority.
module control_decode_comb
  import control_decoder_pkg::*;
(
  input  logic       r_type,
  input  logic       i_type,
  input  logic       load,
  input  logic       store,
  input  logic       branch,
  input  logic       jal,
  input  logic       jalr,
  input  logic       lui,
  input  logic       auipc,
  input  logic [2:0] fun3,
  input  logic       fun7,
  output ctrl_t      ctrl
);

  always_comb begin
    // NOTE: the all-zero default first keeps every path assigned (no latch) and
    // doubles as the NOP word when no strobe is set.
    ctrl = '0;
    if (r_type) begin
      ctrl.reg_write   = 1'b1;
      ctrl.mem_to_reg  = WB_ALU;
      ctrl.alu_control = alu_op(fun3, fun7, 1'b1);
    end else if (i_type) begin
      ctrl.reg_write   = 1'b1;
      ctrl.operand_b   = 1'b1;
      ctrl.imm_sel     = IMM_I;
      ctrl.alu_control = alu_op(fun3, fun7, 1'b0);
    end else if (load) begin
      ctrl.load        = 1'b1;
      ctrl.reg_write   = 1'b1;
      ctrl.mem_to_reg  = WB_MEM;
      ctrl.operand_b   = 1'b1;
      ctrl.imm_sel     = IMM_I;
      ctrl.alu_control = ALU_ADD;
    end else if (store) begin
      ctrl.store       = 1'b1;
      ctrl.mem_en      = 1'b1;
      ctrl.operand_b   = 1'b1;
      ctrl.imm_sel     = IMM_S;
      ctrl.alu_control = ALU_ADD;
    end else if (branch) begin
      // ALU forms the branch target from PC + B-immediate.
      ctrl.branch      = 1'b1;
      ctrl.operand_a   = 1'b1;
      ctrl.operand_b   = 1'b1;
      ctrl.imm_sel     = IMM_B;
      ctrl.alu_control = ALU_ADD;
    end else if (jal) begin
      ctrl.reg_write   = 1'b1;
      ctrl.mem_to_reg  = WB_PC4;
      ctrl.next_sel    = 1'b1;
      ctrl.operand_a   = 1'b1;
      ctrl.operand_b   = 1'b1;
      ctrl.imm_sel     = IMM_J;
      ctrl.alu_control = ALU_ADD;
    end else if (jalr) begin
      ctrl.reg_write   = 1'b1;
      ctrl.mem_to_reg  = WB_ALU;
      ctrl.next_sel    = 1'b1;
      ctrl.operand_b   = 1'b1;
      ctrl.imm_sel     = IMM_I;
      ctrl.alu_control = ALU_ADD;
    end else if (lui) begin
      ctrl.reg_write   = 1'b1;
      ctrl.operand_b   = 1'b1;
      ctrl.imm_sel     = IMM_U;
      ctrl.alu_control = ALU_PASS_B;
    end else if (auipc) begin
      ctrl.reg_write   = 1'b1;
      ctrl.operand_a   = 1'b1;
      ctrl.operand_b   = 1'b1;
      ctrl.imm_sel     = IMM_U;
      ctrl.alu_control = ALU_ADD;
    end
  end

endmodule

// File: rtl/control_decoder.sv
// RV32I main control decoder: registers the decoded control word so every
// datapath control appears one cycle after its strobes.
module control_decoder
  import control_decoder_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] fun3,
  input  logic       fun7,
  input  logic       i_type,
  input  logic       r_type,
  input  logic       load,
  input  logic       store,
  input  logic       branch,
  input  logic       jal,
  input  logic       jalr,
  input  logic       lui,
  input  logic       auipc,
  output logic       Load,
  output logic       Store,
  output logic [1:0] mem_to_reg,
  output logic       reg_write,
  output logic       mem_en,
  output logic       operand_b,
  output logic       operand_a,
  output logic [2:0] imm_sel,
  output logic       Branch,
  output logic       next_sel,
  output logic [3:0] alu_control
);

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;

  control_decode_comb u_decode (
    .r_type (r_type),
    .i_type (i_type),
    .load   (load),
    .store  (store),
    .branch (branch),
    .jal    (jal),
    .jalr   (jalr),
    .lui    (lui),
    .auipc  (auipc),
    .fun3   (fun3),
    .fun7   (fun7),
    .ctrl   (ctrl_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignment for registered state so every flop samples
    // pre-edge values regardless of evaluation order.
    if (!rst_n) ctrl_q <= '0;
    else        ctrl_q <= ctrl_d;
  end

  assign Load        = ctrl_q.load;
  assign Store       = ctrl_q.store;
  assign mem_to_reg  = ctrl_q.mem_to_reg;
  assign reg_write   = ctrl_q.reg_write;
  assign mem_en      = ctrl_q.mem_en;
  assign operand_b   = ctrl_q.operand_b;
  assign operand_a   = ctrl_q.operand_a;
  assign imm_sel     = ctrl_q.imm_sel;
  assign Branch      = ctrl_q.branch;
  assign next_sel    = ctrl_q.next_sel;
  assign alu_control = ctrl_q.alu_control;

endmodule

// File: tb/tb_control_decoder.sv
// Directed bench for control_decoder: drives strobes on the falling edge and
// compares the full registered control word just after each rising edge.
module tb_control_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] fun3;
  logic       fun7;
  logic       i_type, r_type, load, store, branch, jal, jalr, lui, auipc;
  logic       Load, Store, reg_write, mem_en, operand_b, operand_a, Branch, next_sel;
  logic [1:0] mem_to_reg;
  logic [2:0] imm_sel;
  logic [3:0] alu_control;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  control_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fun3        (fun3),
    .fun7        (fun7),
    .i_type      (i_type),
    .r_type      (r_type),
    .load        (load),
    .store       (store),
    .branch      (branch),
    .jal         (jal),
    .jalr        (jalr),
    .lui         (lui),
    .auipc       (auipc),
    .Load        (Load),
    .Store       (Store),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .mem_en      (mem_en),
    .operand_b   (operand_b),
    .operand_a   (operand_a),
    .imm_sel     (imm_sel),
    .Branch      (Branch),
    .next_sel    (next_sel),
    .alu_control (alu_control)
  );

  // Word layout: Load Store mem_to_reg reg_write mem_en b a imm_sel Branch next_sel alu
  function automatic logic [16:0] mk(input logic ld, input logic st, input logic [1:0] m2r,
                                     input logic rw, input logic men, input logic b,
                                     input logic a, input logic [2:0] imm, input logic br,
                                     input logic ns, input logic [3:0] alu);
    return {ld, st, m2r, rw, men, b, a, imm, br, ns, alu};
  endfunction

  function automatic logic [16:0] observed();
    return {Load, Store, mem_to_reg, reg_write, mem_en, operand_b, operand_a,
            imm_sel, Branch, next_sel, alu_control};
  endfunction

  task automatic check(input string tag, input logic [16:0] exp);
    logic [16:0] obs;
    obs = observed();
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Strobe vector order: r i load store branch jal jalr lui auipc
  task automatic drive(input logic [8:0] strobes, input logic [2:0] f3, input logic f7);
    @(negedge clk);
    {r_type, i_type, load, store, branch, jal, jalr, lui, auipc} = strobes;
    fun3 = f3;
    fun7 = f7;
  endtask

  task automatic step(input string tag, input logic [8:0] strobes, input logic [2:0] f3,
                      input logic f7, input logic [16:0] exp);
    drive(strobes, f3, f7);
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  localparam logic [8:0] S_R = 9'b1_0000_0000;
  localparam logic [8:0] S_I = 9'b0_1000_0000;
  localparam logic [8:0] S_LD = 9'b0_0100_0000;
  localparam logic [8:0] S_ST = 9'b0_0010_0000;
  localparam logic [8:0] S_BR = 9'b0_0001_0000;
  localparam logic [8:0] S_JAL = 9'b0_0000_1000;
  localparam logic [8:0] S_JALR = 9'b0_0000_0100;
  localparam logic [8:0] S_LUI = 9'b0_0000_0010;
  localparam logic [8:0] S_AUIPC = 9'b0_0000_0001;

  initial begin
    rst_n = 1'b0;
    {r_type, i_type, load, store, branch, jal, jalr, lui, auipc} = S_R;
    fun3 = 3'b000;
    fun7 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", 17'd0);

    // Release between edges; the next edge decodes the pending R-type ADD.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release_add", mk(0,0,2'b00,1,0,0,0,3'b000,0,0,4'b0000));

    step("r_sub",  S_R, 3'b000, 1'b1, mk(0,0,2'b00,1,0,0,0,3'b000,0,0,4'b0001));
    step("r_sra",  S_R, 3'b101, 1'b1, mk(0,0,2'b00,1,0,0,0,3'b000,0,0,4'b0111));
    step("r_srl",  S_R, 3'b101, 1'b0, mk(0,0,2'b00,1,0,0,0,3'b000,0,0,4'b0110));
    step("r_and",  S_R, 3'b111, 1'b0, mk(0,0,2'b00,1,0,0,0,3'b000,0,0,4'b1001));
    step("r_slt",  S_R, 3'b010, 1'b1, mk(0,0,2'b00,1,0,0,0,3'b000,0,0,4'b0011));
    step("r_or",   S_R, 3'b110, 1'b0, mk(0,0,2'b00,1,0,0,0,3'b000,0,0,4'b1000));
    step("i_addi_f7", S_I, 3'b000, 1'b1, mk(0,0,2'b00,1,0,1,0,3'b000,0,0,4'b0000));
    step("i_srai", S_I, 3'b101, 1'b1, mk(0,0,2'b00,1,0,1,0,3'b000,0,0,4'b0111));
    step("i_srli", S_I, 3'b101, 1'b0, mk(0,0,2'b00,1,0,1,0,3'b000,0,0,4'b0110));
    step("i_sltiu", S_I, 3'b011, 1'b0, mk(0,0,2'b00,1,0,1,0,3'b000,0,0,4'b0100));
    step("i_xori", S_I, 3'b100, 1'b1, mk(0,0,2'b00,1,0,1,0,3'b000,0,0,4'b0101));
    step("i_slli", S_I, 3'b001, 1'b0, mk(0,0,2'b00,1,0,1,0,3'b000,0,0,4'b0010));
    step("load",   S_LD, 3'b010, 1'b1, mk(1,0,2'b01,1,0,1,0,3'b000,0,0,4'b0000));
    step("store",  S_ST, 3'b010, 1'b1, mk(0,1,2'b00,0,1,1,0,3'b001,0,0,4'b0000));
    step("branch", S_BR, 3'b000, 1'b0, mk(0,0,2'b00,0,0,1,1,3'b010,1,0,4'b0000));
    step("branch_f3", S_BR, 3'b101, 1'b1, mk(0,0,2'b00,0,0,1,1,3'b010,1,0,4'b0000));
    step("jal",    S_JAL, 3'b111, 1'b0, mk(0,0,2'b10,1,0,1,1,3'b011,0,1,4'b0000));
    step("jalr",   S_JALR, 3'b000, 1'b1, mk(0,0,2'b00,1,0,1,0,3'b000,0,1,4'b0000));
    step("lui",    S_LUI, 3'b101, 1'b1, mk(0,0,2'b00,1,0,1,0,3'b100,0,0,4'b1111));
    step("auipc",  S_AUIPC, 3'b110, 1'b0, mk(0,0,2'b00,1,0,1,1,3'b100,0,0,4'b0000));
    step("nop",    9'd0, 3'b101, 1'b1, 17'd0);

    step("prio_store_branch", S_ST | S_BR, 3'b000, 1'b0,
         mk(0,1,2'b00,0,1,1,0,3'b001,0,0,4'b0000));
    step("prio_r_i", S_R | S_I, 3'b000, 1'b1, mk(0,0,2'b00,1,0,0,0,3'b000,0,0,4'b0001));
    step("prio_i_load", S_I | S_LD, 3'b101, 1'b1, mk(0,0,2'b00,1,0,1,0,3'b000,0,0,4'b0111));
    step("prio_load_store", S_LD | S_ST, 3'b000, 1'b0,
         mk(1,0,2'b01,1,0,1,0,3'b000,0,0,4'b0000));
    step("prio_branch_jal", S_BR | S_JAL, 3'b000, 1'b0,
         mk(0,0,2'b00,0,0,1,1,3'b010,1,0,4'b0000));
    step("prio_jal_jalr", S_JAL | S_JALR, 3'b000, 1'b0,
         mk(0,0,2'b10,1,0,1,1,3'b011,0,1,4'b0000));
    step("prio_jalr_lui", S_JALR | S_LUI, 3'b000, 1'b0,
         mk(0,0,2'b00,1,0,1,0,3'b000,0,1,4'b0000));
    step("prio_lui_auipc", S_LUI | S_AUIPC, 3'b000, 1'b0,
         mk(0,0,2'b00,1,0,1,0,3'b100,0,0,4'b1111));
    step("prio_all", 9'h1FF, 3'b011, 1'b0, mk(0,0,2'b00,1,0,0,0,3'b000,0,0,4'b0100));

    // Asynchronous reset mid-cycle must clear outputs without a clock edge.
    step("pre_async", S_JAL, 3'b000, 1'b0, mk(0,0,2'b10,1,0,1,1,3'b011,0,1,4'b0000));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 17'd0);
    @(posedge clk);
    #1;
    check("async_reset_hold", 17'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
